// File: rtl/apb4_master_bridge.sv
// APB4 initiator: one valid/ready command becomes a SETUP + ACCESS transfer; completion on a one-cycle rsp strobe.
// Latency: accept -> SETUP -> ACCESS (+1 per wait state) -> rsp; req_ready low while busy, rsp has no backpressure.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    pclk,
  input  logic                    prstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Value the stall counter holds during the last permitted wait cycle
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign req_ready = (state == IDLE);

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state       <= IDLE;
      cnt         <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            paddr  <= req_addr;
            pwrite <= req_write;
            pwdata <= req_wdata;
            // APB4 requires all strobes low on reads
            pstrb  <= req_write ? req_strb : '0;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Bench for apb4_master_bridge: transaction-level timeline model plus directed literal pins and random traffic.
module tb_apb4_master_bridge;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 3;

  logic          pclk;
  logic          prstn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;
  logic          pready, pslverr;

  apb4_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .prstn(prstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // w = ACCESS cycles the slave holds pready low; gap = cycles before the request is presented
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            w;
    logic [DW-1:0] rdata;
    logic          err;
    int            gap;
  } txn_t;

  txn_t q[$];
  txn_t cur, pend;
  int   cyc, t_n, t_l, pres_c;
  bit   act, cur_to, have_pend;

  logic          e_psel, e_pen, e_rdy, e_pwrite, e_rvld, e_rerr, e_rto;
  logic [AW-1:0] e_paddr;
  logic [DW-1:0] e_pwdata, e_rdata;
  logic [SW-1:0] e_pstrb;
  bit            chk_en, chk_rdy;
  int            n_cmp, n_bad;

  int            acc_cyc, rsp_cyc, pen_cnt, hs_cnt, low_run, last_gap;
  logic          psel_q, m_rerr, m_rto;
  logic [DW-1:0] m_rdata;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, a, e);
    end
  endtask

  function automatic txn_t mk(logic wr, logic [AW-1:0] addr, logic [DW-1:0] wdata, logic [SW-1:0] strb,
                              int w, logic [DW-1:0] rdata, logic err, int gap);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb;
    t.w = w; t.rdata = rdata; t.err = err; t.gap = gap;
    return t;
  endfunction

  task automatic zero_model();
    act = 0; have_pend = 0;
    e_psel = 0; e_pen = 0; e_rdy = 1; e_pwrite = 0; e_rvld = 0; e_rerr = 0; e_rto = 0;
    e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_pstrb = '0;
  endtask

  // One clock: advance the timeline model, drive requester and slave for this cycle.
  task automatic step();
    bit busy;
    int k;
    @(posedge pclk);
    #1;
    cyc++;
    e_rvld = 0;
    if (act && cyc == t_n + t_l + 1) begin
      act    = 0;
      e_rvld = 1;
      e_rto  = cur_to;
      e_rerr = cur_to | cur.err;
      e_rdata = (cur_to || cur.wr) ? '0 : cur.rdata;
    end
    if (act && cyc == t_n) begin
      e_paddr = cur.addr; e_pwrite = cur.wr; e_pwdata = cur.wdata;
      e_pstrb = cur.wr ? cur.strb : '0;
    end
    busy   = act && cyc >= t_n;
    e_psel = busy;
    e_pen  = busy && cyc > t_n;
    e_rdy  = !busy;
    if (e_pen) begin
      k = cyc - t_n;
      if (!cur_to && k == cur.w + 1) begin
        pready = 1'b1; prdata = cur.rdata; pslverr = cur.err;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
    end else begin
      pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
    end
    if (!have_pend && q.size() > 0) begin
      pend = q.pop_front();
      have_pend = 1;
      pres_c = cyc + pend.gap;
    end
    req_valid = have_pend && cyc >= pres_c;
    if (req_valid) begin
      req_write = pend.wr; req_addr = pend.addr; req_wdata = pend.wdata; req_strb = pend.strb;
    end else begin
      req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom; req_strb = SW'($urandom);
    end
    if (req_valid && !busy) begin
      cur = pend; have_pend = 0; act = 1;
      t_n = cyc + 1;
      cur_to = (TO > 0) && (pend.w >= TO);
      t_l = cur_to ? TO : pend.w + 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || have_pend || act) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_bound cyc=%0d got=expired expected=idle", cyc);
    end
    step();
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      check("psel", 32'(psel), 32'(e_psel));
      check("penable", 32'(penable), 32'(e_pen));
      check("paddr", 32'(paddr), 32'(e_paddr));
      check("pwrite", 32'(pwrite), 32'(e_pwrite));
      check("pwdata", pwdata, e_pwdata);
      check("pstrb", 32'(pstrb), 32'(e_pstrb));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rvld));
      check("rsp_rdata", rsp_rdata, e_rdata);
      check("rsp_err", 32'(rsp_err), 32'(e_rerr));
      check("rsp_timeout", 32'(rsp_timeout), 32'(e_rto));
      if (chk_rdy) check("req_ready", 32'(req_ready), 32'(e_rdy));
    end
  end

  // Independent observation of DUT activity for the literal pins
  always @(negedge pclk) begin
    if (prstn && req_valid && req_ready) begin
      acc_cyc = cyc;
      hs_cnt++;
    end
    if (penable) pen_cnt++;
    if (rsp_valid) begin
      rsp_cyc = cyc; m_rdata = rsp_rdata; m_rerr = rsp_err; m_rto = rsp_timeout;
    end
    if (psel && !psel_q) last_gap = low_run;
    low_run = psel ? 0 : low_run + 1;
    psel_q = psel;
  end

  initial begin
    int n;
    n_cmp = 0; n_bad = 0; cyc = 0; t_n = 0; t_l = 0; pres_c = 0; cur_to = 0;
    acc_cyc = 0; rsp_cyc = 0; pen_cnt = 0; hs_cnt = 0; low_run = 0; last_gap = 0;
    psel_q = 0; m_rerr = 0; m_rto = 0; m_rdata = '0;
    zero_model();
    prstn = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
    pready = 0; prdata = '0; pslverr = 0;
    chk_en = 1; chk_rdy = 0;
    repeat (3) @(posedge pclk);
    #2 prstn = 1'b1;
    chk_rdy = 1;

    // Zero-wait write
    q.push_back(mk(1'b1, 4'h4, 32'hA5A5_0F0F, 4'hF, 0, $urandom, 1'b0, 0));
    drain();
    check("wr_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
    check("wr_err", 32'(m_rerr), 32'd0);

    // Read with two wait states
    pen_cnt = 0;
    q.push_back(mk(1'b0, 4'h8, $urandom, 4'hF, 2, 32'h1234_5678, 1'b0, 1));
    drain();
    check("rd_penable_cycles", 32'(pen_cnt), 32'd3);
    check("rd_data", m_rdata, 32'h1234_5678);

    // Slave error, then a clean write
    q.push_back(mk(1'b0, 4'hC, $urandom, 4'h3, 0, 32'hDEAD_BEEF, 1'b1, 0));
    drain();
    check("slverr_err", 32'(m_rerr), 32'd1);
    check("slverr_to", 32'(m_rto), 32'd0);
    q.push_back(mk(1'b1, 4'h0, 32'h0000_1111, 4'h1, 1, $urandom, 1'b0, 0));
    drain();
    check("clean_err", 32'(m_rerr), 32'd0);

    // PREADY stuck low -> timeout after TO ACCESS cycles
    pen_cnt = 0;
    q.push_back(mk(1'b0, 4'h2, $urandom, 4'hF, 50, $urandom, 1'b0, 0));
    drain();
    check("to_penable_cycles", 32'(pen_cnt), 32'd3);
    check("to_flag", 32'(m_rto), 32'd1);
    check("to_err", 32'(m_rerr), 32'd1);
    check("to_rdata", m_rdata, 32'd0);

    // Back-to-back writes with req_valid held through the busy period
    hs_cnt = 0;
    q.push_back(mk(1'b1, 4'h0, 32'hCAFE_0000, 4'hF, 0, $urandom, 1'b0, 0));
    q.push_back(mk(1'b1, 4'h4, 32'hCAFE_0004, 4'hC, 0, $urandom, 1'b0, 0));
    drain();
    check("b2b_handshakes", 32'(hs_cnt), 32'd2);
    check("b2b_psel_low_gap", 32'(last_gap), 32'd1);

    // Random traffic
    for (int i = 0; i < 150; i++)
      q.push_back(mk(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                     $urandom_range(0, 4), $urandom, 1'($urandom), $urandom_range(0, 5)));
    drain();

    // Reset asserted during a stalled read
    q.push_back(mk(1'b0, 4'h6, $urandom, 4'hF, 50, $urandom, 1'b0, 0));
    n = 0;
    do begin
      step();
      n++;
    end while (!e_pen && n < 20);
    if (!e_pen) begin
      n_cmp++; n_bad++;
      $display("FAIL reach_access cyc=%0d got=expired expected=access", cyc);
    end
    #2;
    prstn = 1'b0;
    req_valid = 0;
    chk_rdy = 0;
    zero_model();
    #1;
    check("arst_psel", 32'(psel), 32'd0);
    check("arst_penable", 32'(penable), 32'd0);
    repeat (3) @(posedge pclk);
    #2 prstn = 1'b1;
    chk_rdy = 1;
    q.push_back(mk(1'b0, 4'h9, $urandom, 4'hF, 1, 32'h0BAD_F00D, 1'b0, 0));
    drain();
    check("post_reset_rdata", m_rdata, 32'h0BAD_F00D);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- APB4 initiator that turns single-beat requests from a simple valid/ready command port into compliant APB4 SETUP/ACCESS transfers.
- Returns read data and the error status on a one-cycle response strobe.
- Sits between the SoC fabric or a test driver and the APB4 peripherals, for example the GPIO block.
- Provides the requester end of the same bus the peripherals respond to, and adds a bounded PREADY-stall timeout.

Parameters:
- ADDR_WIDTH, 4, width of paddr and req_addr.
- DATA_WIDTH, 32, width of pwdata and prdata. Must be a multiple of 8.
- TIMEOUT, 255, maximum number of ACCESS cycles with pready low before a forced error completion. 0 disables the timeout.

Ports:
- pclk  in  1  APB clock. All logic is on the rising edge.
- prstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_WIDTH  read data. 0 for writes and timeouts.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  completion was forced by the timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_WIDTH  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (prstn low, asynchronous):
  - state=IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - Timeout counter 0.
  - req_ready=1 once prstn is high.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register paddr=req_addr, pwrite=req_write and pwdata=req_wdata.
  - pstrb=req_strb for writes; pstrb=0 for reads (APB4 rule).
  - Next state SETUP.
- SETUP:
  - psel=1, penable=0, req_ready=0.
  - Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1, req_ready=0.
  - If pready=1: rsp_valid=1 next cycle.
    - rsp_rdata=prdata for reads, 0 for writes.
    - rsp_err=pslverr, rsp_timeout=0.
    - Go to IDLE, with psel and penable dropped that same edge.
  - If pready=0: increment the counter. When the counter==TIMEOUT (TIMEOUT>0), complete with rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to IDLE and clear the counter.
- Bus signals:
  - paddr, pwrite, pwdata and pstrb are held stable from SETUP through the last ACCESS cycle.
  - They keep their last value in IDLE; they are not cleared.
- pslverr and prdata are sampled only in ACCESS with pready=1 and ignored otherwise.
- Latency:
  - Command accepted at edge N, SETUP in cycle N+1, ACCESS in N+2.
  - Zero-wait-state completion gives rsp_valid in N+3.
  - Each wait state adds one cycle.
- rsp_valid is a one-cycle pulse with no backpressure. rsp_rdata, rsp_err and rsp_timeout hold their values until the next completion.
- Back-to-back: req_ready is 1 in the rsp_valid cycle, so the next SETUP is at the earliest N+4. There is always at least one psel-low cycle between transfers.
- Requests presented while busy see req_ready=0 and are not consumed; the requester must hold them.
- Reset asserted mid-transfer: psel and penable drop immediately (asynchronously) and no response is issued for the aborted transfer.
- TIMEOUT boundary: with TIMEOUT=3 and pready held low, ACCESS lasts exactly 3 cycles before the forced completion.

Test Plan:
- Write: req addr=0x4, wdata=0xA5A5_0F0F, strb=0xF, pready tied 1 -> psel rises N+1, penable N+2, pwdata=0xA5A5_0F0F, pstrb=0xF; rsp_valid at N+3, rsp_err=0.
- Read with 2 wait states: addr=0x8, pready low 2 ACCESS cycles, then prdata=0x1234_5678 -> penable high 3 cycles; rsp_rdata=0x1234_5678, pstrb=0 throughout.
- Slave error: read with pslverr=1 at pready=1 -> rsp_err=1, rsp_timeout=0. A subsequent clean write returns rsp_err=0.
- Timeout: TIMEOUT=3, pready stuck 0 -> 3 ACCESS cycles, then rsp_valid, rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel low.
- Back-to-back: req_valid held high with two writes (0x0, 0x4) -> second SETUP exactly one psel-low cycle after the first completion. The second command is not accepted while busy.
- Reset mid-ACCESS: prstn low during a stalled read -> psel and penable go to 0 without a clock edge, and no rsp_valid is produced.
